ahb_sram_slave: RTL and testbench
=================================

Name: ahb_sram_slave

Overview:
- AHB-Lite responder (slave) holding on-chip single-port synchronous SRAM.
- Serves the Cortex-M0 system bus: sits behind the bus decoder, driven by HSEL, and answers transfers issued by the processor wrapper.
- Supports byte, halfword and word accesses and programmable wait states.
- A one-entry write buffer with read forwarding lets back-to-back write→read run at zero wait states on one RAM port.

Parameters:
- ADDR_WIDTH, 12, word-address bits; size is 4*2^ADDR_WIDTH bytes. HADDR[ADDR_WIDTH+1:2] indexes, upper bits ignored (aliasing).
- WAIT_STATES, 0, extra data-phase cycles per transfer, 0..15.

Ports:
- CLK  in  1  system clock, shared with the AHB bus.
- RST  in  1  asynchronous, active-high reset.
- HSEL  in  1  slave select from decoder.
- HADDR  in  32  address.
- HTRANS  in  2  transfer type; only NONSEQ/SEQ (HTRANS[1]=1) are active.
- HSIZE  in  3  0=byte, 1=half, 2=word.
- HWRITE  in  1  1=write.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  in  1  bus-wide ready; an address phase is sampled only when it is 1.
- HREADYOUT  out  1  this slave's ready.
- HRDATA  out  32  read data.
- HRESP  out  1  0=OKAY, 1=ERROR.

Behaviour:
- Reset (RST=1, async) values:
  - HREADYOUT=1, HRESP=0, HRDATA=0.
  - FSM=IDLE, wait counter=0, write buffer invalid.
  - RAM contents undefined, not cleared.
- Address phase accepted when HSEL & HTRANS[1] & HREADY. Otherwise no action, and the slave stays/returns to IDLE with HREADYOUT=1, HRESP=0.
- Accepted phase registers: addr, size, write, byte mask.
  - Byte: mask bit HADDR[1:0].
  - Half: mask 0011/1100 selected by HADDR[1].
  - Word: mask 1111.
- Read: RAM address driven in the address-phase cycle.
  - Data appears at the first data-phase cycle and is held in HRDATA until the next read completes.
  - Forwarding: if the write buffer is valid with the same word address, masked buffer bytes replace RAM bytes.
  - HRDATA returns the full word regardless of HSIZE.
- Write: HWDATA is captured into the write buffer (addr, data, mask) on the last data-phase cycle (HREADYOUT=1).
- Buffer drain: the buffer commits to RAM in any cycle where no read address phase is accepted.
  - Drain and new load in the same cycle is legal: old entry is written, new entry is loaded.
  - A write's own address-phase cycle always frees the port, so the buffer never overflows.
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE→WAIT on accepted OKAY transfer when WAIT_STATES>0. Counter loads WAIT_STATES-1; HREADYOUT=0 while in WAIT.
  - WAIT→IDLE when counter=0. HREADYOUT=1 that cycle ends the data phase.
  - Latency: read data/write capture at data-phase cycle 1+WAIT_STATES after the address phase.
  - ERR path (feature enabled only): IDLE→ERR1 (HRESP=1, HREADYOUT=0) → ERR2 (HRESP=1, HREADYOUT=1) → IDLE. An address phase may be accepted in ERR2.
- Pipelining: a new address phase is accepted in the same cycle the previous data phase completes.
- HTRANS=IDLE/BUSY while selected → zero-wait OKAY.
- RST mid-transfer: an uncommitted buffered write is lost. Everything returns to reset values immediately.

Optional Feature:
- Macro: AHB_SRAM_ERR_EN.
- Defined: these accesses take the two-cycle ERROR response, with no buffer load and HRDATA unchanged:
  - HSIZE≥3;
  - halfword with HADDR[0]=1;
  - word with HADDR[1:0]≠0;
  - any HADDR bit above ADDR_WIDTH+1 nonzero.
  - Wait states are not applied to ERROR responses.
- Undefined: no ERR states are generated and HRESP is tied 0.
  - HSIZE≥3 is treated as a word access.
  - Misaligned addresses are aligned down to their size.
  - Upper address bits alias.

Test Plan:
- Reset: assert RST mid-WAIT → HREADYOUT=1, HRESP=0, HRDATA=0 immediately. After release, idle bus keeps HREADYOUT=1.
- Forwarding, WAIT_STATES=0: write word 0xDEADBEEF @0x10, then read @0x10 the next cycle → HRDATA=0xDEADBEEF, zero waits, no stall.
- Byte lanes: word write 0x11223344 @0x20, byte write 0xAA @0x21, half write 0xBEEF @0x22, read @0x20 → 0xBEEFAA44.
- Wait states, WAIT_STATES=2:
  - Read → HREADYOUT low exactly 2 cycles, data valid in the 3rd data-phase cycle.
  - Back-to-back W,R,W,R to distinct addresses → all readbacks correct.
- HREADY gating: HSEL=1, HTRANS=NONSEQ write with HREADY=0 → no write occurs; later read returns the old value.
- With AHB_SRAM_ERR_EN: word write @0x06 → ERR1/ERR2 two-cycle response, memory @0x04 unchanged. Without the macro, the same access writes @0x04.

Source files
------------

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM responder: single-port sync RAM, one-entry write buffer with read
// forwarding, programmable wait states. Define AHB_SRAM_ERR_EN for ERROR responses.
module ahb_sram_slave #(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic        HRESP
);
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  dphase_q, dphase_d;
    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            mask_q, mask_d;
    logic                  buf_valid_q, buf_valid_d;
    logic [ADDR_WIDTH-1:0] buf_addr_q, buf_addr_d;
    logic [31:0]           buf_data_q, buf_data_d;
    logic [3:0]            buf_mask_q, buf_mask_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [3:0]            fwd_mask_q, fwd_mask_d;
    logic [31:0]           fwd_data_q, fwd_data_d;

    logic [31:0]           mem [0:(1 << ADDR_WIDTH) - 1];
    logic [31:0]           ram_rdata_q;
    logic                  ram_re, ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [31:0]           ram_wdata;
    logic [3:0]            ram_be;

    logic                  hready_int, accept, acc_ok, acc_err, addr_err, wr_done;
    logic [ADDR_WIDTH-1:0] haddr_word;
    logic [3:0]            hmask;
    logic [31:0]           rdata_merged;
    logic                  unused_ok;

    assign unused_ok  = ^{HADDR, HTRANS[0]};
    assign haddr_word = HADDR[ADDR_WIDTH+1:2];

`ifdef AHB_SRAM_ERR_EN
    assign addr_err = (HSIZE >= 3'd3)
                   || (HSIZE == 3'd1 && HADDR[0])
                   || (HSIZE == 3'd2 && HADDR[1:0] != 2'b00)
                   || ((HADDR >> (ADDR_WIDTH + 2)) != '0);
    assign HRESP    = (state_q == ST_ERR1) || (state_q == ST_ERR2);
`else
    assign addr_err = 1'b0;
    assign HRESP    = 1'b0;
`endif

    assign hready_int = (state_q != ST_WAIT) && (state_q != ST_ERR1);
    assign HREADYOUT  = hready_int;
    assign accept     = HSEL && HTRANS[1] && HREADY && hready_int;
    assign acc_ok     = accept && !addr_err;
    assign acc_err    = accept && addr_err;
    assign wr_done    = dphase_q && write_q && hready_int;

    always_comb begin
        case (HSIZE)
            3'd0:    hmask = 4'b0001 << HADDR[1:0];
            3'd1:    hmask = HADDR[1] ? 4'b1100 : 4'b0011;
            default: hmask = 4'b1111;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_ERR2: begin
                if (acc_err) begin
                    state_d = ST_ERR1;
                end else if (acc_ok && WAIT_STATES != 0) begin
                    state_d = ST_WAIT;
                    cnt_d   = 4'(WAIT_STATES - 1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - 4'd1;
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        dphase_d = hready_int ? acc_ok : dphase_q;
        addr_d   = addr_q;
        write_d  = write_q;
        mask_d   = mask_q;
        if (acc_ok) begin
            addr_d  = haddr_word;
            write_d = HWRITE;
            mask_d  = hmask;
        end
    end

    // Write data goes straight to RAM when the port is free and nothing is parked;
    // it is only parked in the buffer while a read owns the port.
    always_comb begin
        ram_re      = acc_ok && !HWRITE;
        ram_we      = 1'b0;
        ram_addr    = haddr_word;
        ram_wdata   = buf_data_q;
        ram_be      = buf_mask_q;
        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        buf_mask_d  = buf_mask_q;
        if (!ram_re) begin
            if (buf_valid_q) begin
                ram_we      = 1'b1;
                ram_addr    = buf_addr_q;
                buf_valid_d = 1'b0;
            end else if (wr_done) begin
                ram_we    = 1'b1;
                ram_addr  = addr_q;
                ram_wdata = HWDATA;
                ram_be    = mask_q;
            end
        end
        if (wr_done && (ram_re || buf_valid_q)) begin
            buf_valid_d = 1'b1;
            buf_addr_d  = addr_q;
            buf_data_d  = HWDATA;
            buf_mask_d  = mask_q;
        end
        rd_valid_d = rd_valid_q || ram_re;
        fwd_mask_d = fwd_mask_q;
        fwd_data_d = fwd_data_q;
        if (ram_re) begin
            fwd_data_d = buf_data_d;
            fwd_mask_d = (buf_valid_d && buf_addr_d == haddr_word) ? buf_mask_d : '0;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            rdata_merged[8*i +: 8] = fwd_mask_q[i] ? fwd_data_q[8*i +: 8] : ram_rdata_q[8*i +: 8];
        end
        HRDATA = rd_valid_q ? rdata_merged : '0;
    end

    always_ff @(posedge CLK) begin
        if (ram_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (ram_be[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
            end
        end
        if (ram_re) ram_rdata_q <= mem[ram_addr];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            dphase_q    <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            mask_q      <= '0;
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
            buf_mask_q  <= '0;
            rd_valid_q  <= 1'b0;
            fwd_mask_q  <= '0;
            fwd_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dphase_q    <= dphase_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            mask_q      <= mask_d;
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            buf_mask_q  <= buf_mask_d;
            rd_valid_q  <= rd_valid_d;
            fwd_mask_q  <= fwd_mask_d;
            fwd_data_q  <= fwd_data_d;
        end
    end
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: a zero-wait and a two-wait instance driven by a pipelined
// AHB master, reads checked against a byte-lane memory model through a scoreboard.
module tb_ahb_sram_slave;
    localparam int unsigned AW  = 12;
    localparam int unsigned WS1 = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        hsel [2];
    logic [31:0] haddr [2];
    logic [1:0]  htrans [2];
    logic [2:0]  hsize [2];
    logic        hwrite [2];
    logic [31:0] hwdata [2];
    logic        hready [2];
    logic        hreadyout [2];
    logic [31:0] hrdata [2];
    logic        hresp [2];
    logic        force_nready [2];

    assign hready[0] = hreadyout[0] & ~force_nready[0];
    assign hready[1] = hreadyout[1] & ~force_nready[1];

    ahb_sram_slave #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) u_dut0 (
        .CLK(clk), .RST(rst), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
        .HSIZE(hsize[0]), .HWRITE(hwrite[0]), .HWDATA(hwdata[0]), .HREADY(hready[0]),
        .HREADYOUT(hreadyout[0]), .HRDATA(hrdata[0]), .HRESP(hresp[0])
    );

    ahb_sram_slave #(.ADDR_WIDTH(AW), .WAIT_STATES(WS1)) u_dut2 (
        .CLK(clk), .RST(rst), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
        .HSIZE(hsize[1]), .HWRITE(hwrite[1]), .HWDATA(hwdata[1]), .HREADY(hready[1]),
        .HREADYOUT(hreadyout[1]), .HRDATA(hrdata[1]), .HRESP(hresp[1])
    );

    typedef struct {
        bit          write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] data;
    } tx_t;

    tx_t         txq [$];
    logic [31:0] sb [$];
    bit   [31:0] model [2][0:(1 << AW) - 1];
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic logic [3:0] lane_mask(input logic [31:0] a, input logic [2:0] s);
        case (s)
            3'd0:    return 4'b0001 << a[1:0];
            3'd1:    return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic bit is_err(input tx_t t);
`ifdef AHB_SRAM_ERR_EN
        return (t.size >= 3'd3) || (t.size == 3'd1 && t.addr[0]) ||
               (t.size == 3'd2 && t.addr[1:0] != 2'b00) || (t.addr[31:AW+2] != '0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic push_tx(input bit w, input logic [31:0] a, input logic [2:0] s, input logic [31:0] dat);
        tx_t t;
        t.write = w; t.addr = a; t.size = s; t.data = dat;
        txq.push_back(t);
    endtask

    task automatic drive_idle(input int d);
        hsel[d] = 1'b0; htrans[d] = 2'b00; haddr[d] = '0; hsize[d] = 3'd0; hwrite[d] = 1'b0;
    endtask

    task automatic model_write(input int d, input tx_t t);
        logic [3:0] m;
        m = lane_mask(t.addr, t.size);
        for (int i = 0; i < 4; i++)
            if (m[i]) model[d][t.addr[AW+1:2]][8*i +: 8] = t.data[8*i +: 8];
    endtask

    // Pipelined master: address of the next transfer overlaps the data phase of the previous.
    task automatic run(input int d);
        tx_t cur, prev;
        bit cur_v, prev_v, rdy;
        int waits, cyc, exp_ws;
        logic [31:0] exp;
        prev_v = 1'b0;
        while (txq.size() != 0 || prev_v) begin
            if (txq.size() != 0) begin
                cur = txq.pop_front();
                cur_v = 1'b1;
                hsel[d] = 1'b1; htrans[d] = 2'b10; haddr[d] = cur.addr;
                hsize[d] = cur.size; hwrite[d] = cur.write;
                if (!is_err(cur)) begin
                    if (cur.write) model_write(d, cur);
                    else           sb.push_back(model[d][cur.addr[AW+1:2]]);
                end
            end else begin
                cur_v = 1'b0;
                drive_idle(d);
            end
            hwdata[d] = (prev_v && prev.write) ? prev.data : '0;
            waits = 0;
            cyc = 0;
            do begin
                @(negedge clk);
                rdy = hreadyout[d];
                if (!rdy) begin
                    waits++;
                end else if (prev_v) begin
                    exp_ws = is_err(prev) ? 1 : ((d == 0) ? 0 : int'(WS1));
                    n_cmp++;
                    if (waits !== exp_ws) begin
                        n_bad++;
                        $display("FAIL waits dut%0d addr=%h: got %0d expected %0d", d, prev.addr, waits, exp_ws);
                    end
                    n_cmp++;
                    if (hresp[d] !== is_err(prev)) begin
                        n_bad++;
                        $display("FAIL hresp dut%0d addr=%h: got %b expected %b", d, prev.addr, hresp[d], is_err(prev));
                    end
                    if (!prev.write && !is_err(prev)) begin
                        exp = sb.pop_front();
                        n_cmp++;
                        if (hrdata[d] !== exp) begin
                            n_bad++;
                            $display("FAIL hrdata dut%0d addr=%h: got %h expected %h", d, prev.addr, hrdata[d], exp);
                        end
                    end
                end
                @(posedge clk);
                #1;
                cyc++;
            end while (!rdy && cyc < 32);
            if (!rdy) begin
                n_cmp++;
                n_bad++;
                $display("FAIL timeout dut%0d: HREADYOUT stuck low got 0 expected 1", d);
            end
            prev = cur;
            prev_v = cur_v;
        end
        drive_idle(d);
        hwdata[d] = '0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            drive_idle(d); hwdata[d] = '0; force_nready[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_cmp++; if (hreadyout[d] !== 1'b1) begin n_bad++; $display("FAIL rst_hreadyout dut%0d: got %b expected 1", d, hreadyout[d]); end
            n_cmp++; if (hresp[d] !== 1'b0)     begin n_bad++; $display("FAIL rst_hresp dut%0d: got %b expected 0", d, hresp[d]); end
            n_cmp++; if (hrdata[d] !== 32'h0)   begin n_bad++; $display("FAIL rst_hrdata dut%0d: got %h expected 0", d, hrdata[d]); end
        end
        @(posedge clk);
        #1 rst = 1'b0;
        push_tx(1, 32'h40, 3'd2, 32'h12345678);
        push_tx(0, 32'h40, 3'd2, 32'h0);
        run(1);
        hsel[1] = 1'b1; htrans[1] = 2'b10; haddr[1] = 32'h40; hsize[1] = 3'd2; hwrite[1] = 1'b0;
        @(posedge clk);
        #1 drive_idle(1);
        @(negedge clk);
        n_cmp++; if (hreadyout[1] !== 1'b0) begin n_bad++; $display("FAIL pre_rst_wait: got %b expected 0", hreadyout[1]); end
        #1 rst = 1'b1;
        #1;
        n_cmp++; if (hreadyout[1] !== 1'b1) begin n_bad++; $display("FAIL midrst_hreadyout: got %b expected 1", hreadyout[1]); end
        n_cmp++; if (hresp[1] !== 1'b0)     begin n_bad++; $display("FAIL midrst_hresp: got %b expected 0", hresp[1]); end
        n_cmp++; if (hrdata[1] !== 32'h0)   begin n_bad++; $display("FAIL midrst_hrdata: got %h expected 0", hrdata[1]); end
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_cmp++; if (hreadyout[1] !== 1'b1) begin n_bad++; $display("FAIL idle_hreadyout: got %b expected 1", hreadyout[1]); end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_forwarding;
        push_tx(1, 32'h10, 3'd2, 32'hDEADBEEF);
        push_tx(0, 32'h10, 3'd2, 32'h0);
        run(0);
    endtask

    task automatic test_byte_lanes;
        push_tx(1, 32'h20, 3'd2, 32'h11223344);
        push_tx(1, 32'h21, 3'd0, 32'h0000AA00);
        push_tx(1, 32'h22, 3'd1, 32'hBEEF0000);
        push_tx(0, 32'h20, 3'd2, 32'h0);
        run(0);
    endtask

    task automatic test_back_to_back;
        push_tx(1, 32'h80, 3'd2, 32'hA5A55A5A);
        push_tx(0, 32'h80, 3'd2, 32'h0);
        push_tx(1, 32'h84, 3'd2, 32'h0BADF00D);
        push_tx(0, 32'h80, 3'd0, 32'h0);
        push_tx(1, 32'h88, 3'd2, 32'h76543210);
        push_tx(0, 32'h84, 3'd2, 32'h0);
        push_tx(0, 32'h88, 3'd1, 32'h0);
        run(1);
    endtask

    task automatic test_hready_gating;
        push_tx(1, 32'h30, 3'd2, 32'hCAFEF00D);
        run(0);
        hsel[0] = 1'b1; htrans[0] = 2'b10; haddr[0] = 32'h30; hsize[0] = 3'd2; hwrite[0] = 1'b1;
        force_nready[0] = 1'b1;
        @(posedge clk);
        #1;
        drive_idle(0);
        force_nready[0] = 1'b0;
        hwdata[0] = 32'hBADBAD00;
        @(negedge clk);
        n_cmp++; if (hreadyout[0] !== 1'b1) begin n_bad++; $display("FAIL gated_stall: got %b expected 1", hreadyout[0]); end
        @(posedge clk);
        #1 hwdata[0] = '0;
        push_tx(0, 32'h30, 3'd2, 32'h0);
        run(0);
    endtask

    task automatic test_err;
        push_tx(1, 32'h04, 3'd2, 32'h01020304);
        push_tx(1, 32'h08, 3'd2, 32'h55667788);
        push_tx(1, 32'h0C, 3'd2, 32'h13579BDF);
        push_tx(1, 32'h06, 3'd2, 32'hFFFFFFFF);
        push_tx(1, 32'h00010008, 3'd0, 32'h000000EE);
        push_tx(1, 32'h0C, 3'd3, 32'h99887766);
        push_tx(0, 32'h04, 3'd2, 32'h0);
        push_tx(0, 32'h08, 3'd2, 32'h0);
        push_tx(0, 32'h0C, 3'd2, 32'h0);
        run(0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_forwarding();
        test_byte_lanes();
        test_back_to_back();
        test_hready_gating();
        test_err();
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
